noc_vc_scheduler: RTL and testbench
===================================

NOC_VC_SCHEDULER -- requirements
Module: noc_vc_scheduler

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 34, flit width: 32 data bits plus 2 type bits in the MSBs.
REQ-002 SHALL have parameter VCHANNELS, default 3, number of virtual channels.
REQ-003 SHALL have parameter PACKET_ATOMIC, default 0; 1 means a packet holds the link until its last flit.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port in_flit, input, VCHANNELS*FLIT_WIDTH, per-VC source flits; VC v occupies bits [v*FLIT_WIDTH +: FLIT_WIDTH].
REQ-007 SHALL have ports in_valid (input) and in_ready (output), VCHANNELS each, per-VC handshake.
REQ-008 SHALL have port out_flit, output, FLIT_WIDTH, shared link flit.
REQ-009 SHALL have port out_valid, output, VCHANNELS, one-hot or zero.
REQ-010 SHALL have port out_ready, input, VCHANNELS, per-VC downstream ready; it SHALL NOT depend combinationally on out_valid.
REQ-011 SHALL have port proto_err, output, VCHANNELS, sticky per-VC framing-error flags.
REQ-012 SHALL have port clr_err, input, 1, clears all proto_err bits.

Function
REQ-013 SHALL decode flit type from bits [FLIT_WIDTH-1 -: 2]: 00 payload, 01 header, 10 last, 11 single.
REQ-014 SHALL keep one holding register (flit plus valid bit) per VC; an input transfer occurs when in_valid[v] and in_ready[v] are both 1.
REQ-015 SHALL drive in_ready[v] = ~hold_valid[v] | fire[v], with fire[v] = out_valid[v] & out_ready[v]; full-throughput streaming is one flit per cycle per VC.
REQ-016 SHALL present an accepted flit on the output no earlier than the cycle after acceptance; minimum latency is 1 cycle.
REQ-017 SHALL set eligible[v] = hold_valid[v] & out_ready[v] & (~locked | lock_vc == v).
REQ-018 SHALL grant at most one eligible VC per cycle, round-robin; the search starts at last-fired VC + 1 and wraps modulo VCHANNELS; the pointer is unchanged when nothing fires.
REQ-019 SHALL drive out_valid = onehot(grant) and out_flit = hold_flit[grant]; with no grant, out_valid = 0 and out_flit = 0.
REQ-020 SHALL, when PACKET_ATOMIC=1, set locked and lock_vc=v when a header fires on v, and clear locked when a last flit fires on v; single flits never lock.
REQ-021 SHALL, when PACKET_ATOMIC=0, never assert locked; VCs interleave per flit.
REQ-022 SHALL run a per-VC framing FSM on accepted input flits with states IDLE and IN_PKT:
- IDLE: header -> IN_PKT; single -> IDLE; payload or last -> set error, stay IDLE.
- IN_PKT: payload -> IN_PKT; last -> IDLE; header -> set error, IN_PKT; single -> set error, IDLE.
REQ-023 SHALL keep proto_err[v] set until a cycle with clr_err=1; if clr_err and a new error occur on v in the same cycle, proto_err[v] SHALL be 1 afterwards.
REQ-024 SHALL forward erroneous flits unchanged; it SHALL never drop or reorder flits within a VC.

Reset
REQ-025 SHALL, while rst=0, clear all hold_valid bits, the RR pointer (to 0), locked, lock_vc, every FSM (to IDLE) and proto_err.
REQ-026 SHALL force out_valid=0, out_flit=0 and in_ready=0 while rst=0, including reset asserted mid-packet.

Structure
REQ-027 SHALL take flit-type constants and the type-field position from the shared lisnoc definitions package; no local redefinition.
REQ-028 SHALL instantiate one sub-module, noc_vc_rr_arbiter (parameter N; inputs req[N] and advance; output one-hot gnt[N]; holds the rotating pointer).

Verification
REQ-029 SHALL cover single-flit latency: after reset, VC1 accepts {2'b11,32'h12345678} at cycle N -> at cycle N+1, out_valid=3'b010 and out_flit=34'h3_12345678.
REQ-030 SHALL cover round-robin fairness: all VCs continuously valid, out_ready=3'b111 -> grants 0,1,2,0,1,2, one flit per cycle.
REQ-031 SHALL cover per-VC backpressure: VC0 holding a flit with out_ready[0]=0 while VC2 streams -> VC2 fires every cycle and in_ready[0]=0; VC0 fires in the first cycle out_ready[0]=1 after its RR turn.
REQ-032 SHALL cover atomicity with PACKET_ATOMIC=1: VC0 sends header, payload, payload, last while VC1 offers a single -> VC1 fires only in the cycle after VC0's last.
REQ-033 SHALL cover framing errors: payload on idle VC2 -> proto_err=3'b100 next cycle and held; a clr_err pulse clears it; clr_err coinciding with a new error leaves the bit at 1.
REQ-034 SHALL cover reset mid-packet: rst=0 while locked on VC0 -> out_valid=0 and in_ready=0 immediately; after release, lock is cleared and VC1 is granted first.

Source files
------------

// File: rtl/lisnoc_pkg.sv
// Shared lisnoc flit definitions: type encodings, type-field
// position and the per-VC framing states.
package lisnoc_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEADER  = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  // The type field sits in the top bits of every flit.
  function automatic int flit_type_lsb(input int flit_width);
    return flit_width - FLIT_TYPE_W;
  endfunction

endpackage

// File: rtl/noc_vc_rr_arbiter.sv
// Rotating-priority arbiter; the search starts one past the
// last granted requester whenever advance is set.
module noc_vc_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        gidx = PW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/noc_vc_scheduler.sv
// Per-VC holding registers multiplexed onto one link with
// round-robin grant, optional packet locking and framing checks.
module noc_vc_scheduler
  import lisnoc_pkg::*;
#(
  parameter int FLIT_WIDTH    = 34,
  parameter int VCHANNELS     = 3,
  parameter int PACKET_ATOMIC = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VCHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]            in_valid,
  output logic [VCHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]           out_flit,
  output logic [VCHANNELS-1:0]            out_valid,
  input  logic [VCHANNELS-1:0]            out_ready,
  output logic [VCHANNELS-1:0]            proto_err,
  input  logic                            clr_err
);

  localparam int TL = flit_type_lsb(FLIT_WIDTH);
  localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  logic [FLIT_WIDTH-1:0] hold_flit [VCHANNELS];
  logic [VCHANNELS-1:0]  hold_valid;
  logic [VCHANNELS-1:0]  eligible;
  logic [VCHANNELS-1:0]  gnt;
  logic [VCHANNELS-1:0]  fire;
  logic [VCHANNELS-1:0]  accept;
  logic [VCHANNELS-1:0]  pkt_state;
  logic [VCHANNELS-1:0]  pkt_nxt;
  logic [VCHANNELS-1:0]  frame_err;
  logic                  locked;
  logic [VW-1:0]         lock_vc;
  logic [VW-1:0]         gnt_idx;
  flit_type_e            out_type;
  flit_type_e            in_type [VCHANNELS];

  always_comb begin
    eligible = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      eligible[v] = hold_valid[v] & out_ready[v] &
                    (~locked | (lock_vc == VW'(v)));
    end
  end

  noc_vc_rr_arbiter #(
    .N(VCHANNELS)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst),
    .req    (eligible),
    .advance(|fire),
    .gnt    (gnt)
  );

  // Outputs are gated by reset so nothing leaks during a mid-packet reset.
  assign out_valid = rst ? gnt : '0;
  assign fire      = out_valid & out_ready;
  assign in_ready  = rst ? (~hold_valid | fire) : '0;
  assign accept    = in_valid & in_ready;

  always_comb begin
    out_flit = '0;
    gnt_idx  = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      if (out_valid[v]) begin
        out_flit = hold_flit[v];
        gnt_idx  = VW'(v);
      end
    end
  end

  assign out_type = flit_type_e'(out_flit[TL +: FLIT_TYPE_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= '0;
      for (int v = 0; v < VCHANNELS; v++) begin
        hold_flit[v] <= '0;
      end
    end else begin
      for (int v = 0; v < VCHANNELS; v++) begin
        if (accept[v]) begin
          hold_flit[v]  <= in_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
          hold_valid[v] <= 1'b1;
        end else if (fire[v]) begin
          hold_valid[v] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked  <= 1'b0;
      lock_vc <= '0;
    end else if (PACKET_ATOMIC != 0 && |fire) begin
      if (out_type == FLIT_HEADER) begin
        locked  <= 1'b1;
        lock_vc <= gnt_idx;
      end else if (out_type == FLIT_LAST) begin
        locked  <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < VCHANNELS; v++) begin
      in_type[v] = flit_type_e'(in_flit[v*FLIT_WIDTH + TL +: FLIT_TYPE_W]);
    end
  end

  // Framing is tracked on accepted input flits; errors never block traffic.
  always_comb begin
    pkt_nxt   = pkt_state;
    frame_err = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      if (accept[v]) begin
        if (pkt_state[v] == ST_IDLE) begin
          unique case (in_type[v])
            FLIT_HEADER:  pkt_nxt[v] = ST_IN_PKT;
            FLIT_SINGLE:  pkt_nxt[v] = ST_IDLE;
            FLIT_PAYLOAD: frame_err[v] = 1'b1;
            FLIT_LAST:    frame_err[v] = 1'b1;
          endcase
        end else begin
          unique case (in_type[v])
            FLIT_PAYLOAD: pkt_nxt[v] = ST_IN_PKT;
            FLIT_LAST:    pkt_nxt[v] = ST_IDLE;
            FLIT_HEADER:  frame_err[v] = 1'b1;
            FLIT_SINGLE: begin
              frame_err[v] = 1'b1;
              pkt_nxt[v]   = ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_state <= '0;
      proto_err <= '0;
    end else begin
      pkt_state <= pkt_nxt;
      proto_err <= (proto_err & ~{VCHANNELS{clr_err}}) | frame_err;
    end
  end

endmodule

// File: tb/tb_noc_vc_scheduler.sv
// Directed and random checks of noc_vc_scheduler, interleaved
// (dut0) and packet-atomic (dut1), against a queue-level model.
module tb_noc_vc_scheduler;

  localparam int FW = 34;
  localparam int NV = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NV*FW-1:0] in_flit;
  logic [NV-1:0]    in_valid;
  logic [NV-1:0]    out_ready;
  logic             clr_err;

  logic [NV-1:0] in_ready0, out_valid0, proto_err0;
  logic [NV-1:0] in_ready1, out_valid1, proto_err1;
  logic [FW-1:0] out_flit0, out_flit1;

  int checks = 0;
  int failures = 0;

  noc_vc_scheduler #(
    .FLIT_WIDTH(FW), .VCHANNELS(NV), .PACKET_ATOMIC(0)
  ) dut0 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready0), .out_flit(out_flit0), .out_valid(out_valid0),
    .out_ready(out_ready), .proto_err(proto_err0), .clr_err(clr_err)
  );

  noc_vc_scheduler #(
    .FLIT_WIDTH(FW), .VCHANNELS(NV), .PACKET_ATOMIC(1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready1), .out_flit(out_flit1), .out_valid(out_valid1),
    .out_ready(out_ready), .proto_err(proto_err1), .clr_err(clr_err)
  );

  // model state; index 0 = interleaved, 1 = atomic
  logic [FW-1:0] m_flit  [2][NV];
  bit            m_full  [2][NV];
  bit            m_inpkt [2][NV];
  int            m_last  [2];
  int            m_owner [2];
  logic [NV-1:0] m_err   [2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_flit(int v, logic [1:0] t, logic [31:0] d);
    in_flit[v*FW +: FW] = {t, d};
  endtask

  task automatic model_reset(int i);
    for (int v = 0; v < NV; v++) begin
      m_full[i][v]  = 0;
      m_inpkt[i][v] = 0;
      m_flit[i][v]  = '0;
    end
    m_last[i]  = NV - 1;
    m_owner[i] = -1;
    m_err[i]   = '0;
  endtask

  task automatic model_eval(input int i, output logic [NV-1:0] ov,
                            output logic [FW-1:0] of,
                            output logic [NV-1:0] ir);
    ov = '0;
    of = '0;
    ir = '0;
    if (rst) begin
      for (int k = 1; k <= NV; k++) begin
        int v;
        v = (m_last[i] + k) % NV;
        if (ov == '0 && m_full[i][v] && out_ready[v] &&
            (m_owner[i] < 0 || m_owner[i] == v)) begin
          ov[v] = 1'b1;
          of = m_flit[i][v];
        end
      end
      for (int v = 0; v < NV; v++) ir[v] = !m_full[i][v] || ov[v];
    end
  endtask

  task automatic model_commit(int i);
    logic [NV-1:0] ov, ir;
    logic [FW-1:0] of;
    logic [1:0] t;
    if (!rst) begin
      model_reset(i);
      return;
    end
    model_eval(i, ov, of, ir);
    if (clr_err) m_err[i] = '0;
    for (int v = 0; v < NV; v++) begin
      if (ov[v]) begin
        m_full[i][v] = 0;
        m_last[i] = v;
        if (i == 1) begin
          if (of[FW-1 -: 2] == 2'b01) m_owner[i] = v;
          else if (of[FW-1 -: 2] == 2'b10) m_owner[i] = -1;
        end
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (in_valid[v] && ir[v]) begin
        m_full[i][v] = 1;
        m_flit[i][v] = in_flit[v*FW +: FW];
        t = in_flit[v*FW + FW - 1 -: 2];
        if (!m_inpkt[i][v]) begin
          if (t == 2'b01) m_inpkt[i][v] = 1;
          else if (t != 2'b11) m_err[i][v] = 1'b1;
        end else begin
          if (t == 2'b10) m_inpkt[i][v] = 0;
          else if (t == 2'b01) m_err[i][v] = 1'b1;
          else if (t == 2'b11) begin
            m_err[i][v] = 1'b1;
            m_inpkt[i][v] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [NV-1:0] ov, ir;
    logic [FW-1:0] of;
    model_eval(0, ov, of, ir);
    chk("m0_out_valid", out_valid0, ov);
    chk("m0_out_flit", out_flit0, of);
    chk("m0_in_ready", in_ready0, ir);
    chk("m0_proto_err", proto_err0, m_err[0]);
    model_eval(1, ov, of, ir);
    chk("m1_out_valid", out_valid1, ov);
    chk("m1_out_flit", out_flit1, of);
    chk("m1_in_ready", in_ready1, ir);
    chk("m1_proto_err", proto_err1, m_err[1]);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    check_model();
    @(posedge clk);
    model_commit(0);
    model_commit(1);
    #1;
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
  endtask

  task automatic do_reset();
    in_valid = '0;
    clr_err = 1'b0;
    assert_reset();
    settle();
    advance();
    advance();
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    in_flit = '0;
    in_valid = '0;
    out_ready = '0;
    clr_err = 1'b0;
    assert_reset();

    // reset state
    settle();
    chk("rst_in_ready", in_ready0, 3'b000);
    chk("rst_out_valid", out_valid0, 3'b000);
    chk("rst_out_flit", out_flit0, 34'h0);
    chk("rst_proto_err", proto_err0, 3'b000);
    advance();
    rst = 1'b1;

    // single-flit latency
    out_ready = 3'b111;
    in_valid = 3'b010;
    set_flit(1, 2'b11, 32'h12345678);
    settle();
    chk("lat_accept", in_ready0[1], 1'b1);
    chk("lat_no_early", out_valid0, 3'b000);
    advance();
    in_valid = '0;
    settle();
    chk("lat_valid", out_valid0, 3'b010);
    chk("lat_flit", out_flit0, 34'h3_12345678);
    advance();

    // round-robin fairness
    do_reset();
    out_ready = 3'b111;
    in_valid = 3'b111;
    for (int v = 0; v < NV; v++) set_flit(v, 2'b11, 32'(v * 256));
    settle();
    chk("rr_fill", out_valid0, 3'b000);
    advance();
    for (int c = 1; c <= 6; c++) begin
      for (int v = 0; v < NV; v++) set_flit(v, 2'b11, 32'(v * 256 + c));
      settle();
      chk("rr_grant0", out_valid0, 3'b001 << ((c - 1) % 3));
      chk("rr_grant1", out_valid1, 3'b001 << ((c - 1) % 3));
      advance();
    end
    in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      advance();
    end

    // per-VC backpressure
    out_ready = 3'b100;
    in_valid = 3'b001;
    set_flit(0, 2'b11, 32'hA0);
    settle();
    advance();
    in_valid = 3'b100;
    set_flit(2, 2'b11, 32'hA200);
    settle();
    chk("bp_hold", out_valid0, 3'b000);
    chk("bp_rdy0", in_ready0[0], 1'b0);
    advance();
    for (int k = 1; k <= 4; k++) begin
      set_flit(2, 2'b11, 32'hA200 + 32'(k));
      settle();
      chk("bp_vc2_fire", out_valid0, 3'b100);
      chk("bp_rdy0_low", in_ready0[0], 1'b0);
      chk("bp_rdy2_high", in_ready0[2], 1'b1);
      advance();
    end
    out_ready = 3'b101;
    settle();
    chk("bp_vc0_turn", out_valid0, 3'b001);
    chk("bp_vc0_flit", out_flit0, {2'b11, 32'hA0});
    advance();
    in_valid = '0;
    settle();
    chk("bp_vc2_after", out_valid0, 3'b100);
    advance();
    settle();
    advance();

    // packet atomicity
    do_reset();
    out_ready = 3'b111;
    in_valid = 3'b011;
    set_flit(0, 2'b01, 32'hB0);
    set_flit(1, 2'b11, 32'hC1);
    settle();
    chk("atom_idle", out_valid1, 3'b000);
    advance();
    in_valid = 3'b001;
    set_flit(0, 2'b00, 32'hB1);
    settle();
    chk("atom_hdr", out_valid1, 3'b001);
    chk("atom_hdr_flit", out_flit1, {2'b01, 32'hB0});
    chk("ilv_hdr", out_valid0, 3'b001);
    advance();
    set_flit(0, 2'b00, 32'hB2);
    settle();
    chk("atom_pl1", out_valid1, 3'b001);
    chk("ilv_vc1", out_valid0, 3'b010);
    advance();
    set_flit(0, 2'b10, 32'hB3);
    settle();
    chk("atom_pl2", out_valid1, 3'b001);
    advance();
    in_valid = '0;
    settle();
    chk("atom_last", out_valid1, 3'b001);
    chk("atom_last_type", out_flit1[FW-1 -: 2], 2'b10);
    advance();
    settle();
    chk("atom_vc1", out_valid1, 3'b010);
    chk("atom_vc1_flit", out_flit1, {2'b11, 32'hC1});
    advance();
    for (int c = 0; c < 3; c++) begin
      settle();
      advance();
    end

    // framing errors
    do_reset();
    out_ready = 3'b111;
    in_valid = 3'b100;
    set_flit(2, 2'b00, 32'hD2);
    settle();
    chk("err_none", proto_err0, 3'b000);
    advance();
    in_valid = '0;
    settle();
    chk("err_set", proto_err0, 3'b100);
    advance();
    settle();
    chk("err_held", proto_err0, 3'b100);
    clr_err = 1'b1;
    advance();
    clr_err = 1'b0;
    settle();
    chk("err_clr", proto_err0, 3'b000);
    advance();
    clr_err = 1'b1;
    in_valid = 3'b100;
    set_flit(2, 2'b00, 32'hD3);
    settle();
    advance();
    clr_err = 1'b0;
    in_valid = '0;
    settle();
    chk("err_clr_collide", proto_err0, 3'b100);
    advance();

    // reset mid-packet
    in_valid = 3'b011;
    set_flit(0, 2'b01, 32'hE0);
    set_flit(1, 2'b11, 32'hE1);
    settle();
    advance();
    in_valid = '0;
    settle();
    chk("mid_hdr", out_valid1, 3'b001);
    advance();
    settle();
    chk("mid_locked", out_valid1, 3'b000);
    assert_reset();
    #1;
    chk("mid_rst_valid", out_valid1, 3'b000);
    chk("mid_rst_ready", in_ready1, 3'b000);
    chk("mid_rst_flit", out_flit1, 34'h0);
    advance();
    advance();
    rst = 1'b1;
    in_valid = 3'b010;
    set_flit(1, 2'b11, 32'hF1);
    settle();
    advance();
    in_valid = '0;
    settle();
    chk("mid_vc1_first", out_valid1, 3'b010);
    chk("mid_vc1_flit", out_flit1, {2'b11, 32'hF1});
    advance();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int v = 0; v < NV; v++) begin
        set_flit(v, 2'($urandom_range(3)), $urandom);
      end
      in_valid = 3'($urandom);
      out_ready = 3'($urandom);
      clr_err = ($urandom_range(15) == 0);
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
